// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU and its program sequencer.
//
// Contents:
//   - ALU opcode encodings (3-bit)
//   - Sequencer FSM state encodings (3-bit localparams)
//   - Instruction word layout: [19]=halt, [18:16]=opcode, [15:8]=a, [7:0]=b
//   - instr_t view of the instruction word and a decode helper
package cpu_pkg;

  // Instruction word geometry
  localparam int unsigned InstrWidth = 20;
  localparam int unsigned HALT_BIT   = 19;
  localparam int unsigned OP_MSB     = 18;
  localparam int unsigned OP_LSB     = 16;
  localparam int unsigned A_MSB      = 15;
  localparam int unsigned A_LSB      = 8;
  localparam int unsigned B_MSB      = 7;
  localparam int unsigned B_LSB      = 0;

  // ALU opcodes understood by the CPU control unit
  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpNot = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpShr = 3'b111;

  // Sequencer FSM states
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StIssue   = 3'd2;
  localparam logic [2:0] StSave    = 3'd3;
  localparam logic [2:0] StCapture = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  typedef struct packed {
    logic       halt;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } instr_t;

  function automatic instr_t decode_instr(input logic [InstrWidth-1:0] word);
    instr_t d;
    d.halt = word[HALT_BIT];
    d.op   = word[OP_MSB:OP_LSB];
    d.a    = word[A_MSB:A_LSB];
    d.b    = word[B_MSB:B_LSB];
    return d;
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Instruction store for the program sequencer.
//
// Depth x Width array with one synchronous write port and one synchronous read port.
// The read register only updates when re_i is high, so it doubles as the sequencer's
// instruction register and holds the fetched word for the rest of the instruction.
// No reset: contents and the read register survive reset.
//
// Ports:
//   clk_i    clock, rising edge
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   re_i     read enable
//   raddr_i  read address
//   rdata_o  registered read data
module seq_prog_mem #(
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4,
  parameter int unsigned Width = 20
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer driving the 8-bit CPU datapath.
//
// Holds a small instruction store, fetches words in address order, presents the decoded
// opcode/a/b to the CPU, strobes save, then captures the CPU's registered result.
// Each instruction takes four cycles: FETCH, ISSUE, SAVE, CAPTURE. After the last
// instruction the FSM spends one cycle in DONE (done pulse) and returns to IDLE.
//
// Configuration macro:
//   SEQ_LOOP_EN  when defined, the halt bit or the last address wraps pc to 0 and keeps
//                executing; stop sampled in CAPTURE ends the run (stop beats the wrap).
//                When undefined, stop is ignored and the run ends at halt/last address.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   prog_we     store write enable, honoured only while busy=0
//   prog_addr   store write address
//   prog_wdata  store write data
//   start       begin execution at address 0 (ignored while busy=1)
//   stop        end loop execution (SEQ_LOOP_EN only)
//   result_in   CPU registered ALU result
//   opcode      opcode to CPU control unit
//   a, b        operands to CPU
//   save        one-cycle save strobe to CPU result register
//   result_out  last captured result
//   pc          address of current instruction
//   busy        high from the cycle after start until DONE is exited
//   done        one-cycle pulse at program end
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned INSTR_W = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         result_in,
  output logic [2:0]         opcode,
  output logic [7:0]         a,
  output logic [7:0]         b,
  output logic               save,
  output logic [7:0]         result_out,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               busy_q, busy_d;
  logic [2:0]         opcode_q, opcode_d;
  logic [7:0]         a_q, a_d;
  logic [7:0]         b_q, b_d;
  logic [7:0]         result_q, result_d;

  logic [INSTR_W-1:0] instr_word;
  instr_t             instr;
  logic               mem_we;
  logic               mem_re;
  logic               last_instr;

  // Host writes are locked out for the whole run, including the DONE cycle.
  assign mem_we = prog_we & ~busy_q;
  assign mem_re = (state_q == StFetch);

  seq_prog_mem #(
    .Depth (DEPTH),
    .AddrW (ADDR_W),
    .Width (INSTR_W)
  ) u_prog_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_wdata),
    .re_i    (mem_re),
    .raddr_i (pc_q),
    .rdata_o (instr_word)
  );

  assign instr      = decode_instr(instr_word);
  assign last_instr = instr.halt | (pc_q == LastAddr);

`ifndef SEQ_LOOP_EN
  logic unused_stop;
  assign unused_stop = stop;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    busy_d   = busy_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          pc_d    = '0;
          busy_d  = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        state_d = StIssue;
      end
      StIssue: begin
        // Operands are held until the next ISSUE so the CPU sees stable inputs.
        opcode_d = instr.op;
        a_d      = instr.a;
        b_d      = instr.b;
        state_d  = StSave;
      end
      StSave: begin
        state_d = StCapture;
      end
      StCapture: begin
        result_d = result_in;
`ifdef SEQ_LOOP_EN
        if (stop) begin
          state_d = StDone;
        end else if (last_instr) begin
          pc_d    = '0;
          state_d = StFetch;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = StFetch;
        end
`else
        if (last_instr) begin
          state_d = StDone;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = StFetch;
        end
`endif
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      busy_q   <= 1'b0;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      busy_q   <= busy_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign opcode     = opcode_q;
  assign a          = a_q;
  assign b          = b_q;
  assign save       = (state_q == StSave);
  assign done       = (state_q == StDone);
  assign result_out = result_q;
  assign pc         = pc_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer. A simple CPU model turns each save strobe into
// a registered ALU result; the reference model walks the program image to predict the
// executed addresses, save/done timing and final result.
module tb_instr_sequencer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [19:0] prog_wdata = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  result_in;
  logic [2:0]  opcode;
  logic [7:0]  a, b, result_out;
  logic        save, busy, done;
  logic [3:0]  pc;

  int checks = 0;
  int failures = 0;

  logic [19:0] ref_mem [DEPTH];
  int          exp_q [$];
  logic [7:0]  cpu_res;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .start      (start),
    .stop       (stop),
    .result_in  (result_in),
    .opcode     (opcode),
    .a          (a),
    .b          (b),
    .save       (save),
    .result_out (result_out),
    .pc         (pc),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] x,
                                     input logic [7:0] y);
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return ~x;
      3'd6: return x << y[2:0];
      default: return x >> y[2:0];
    endcase
  endfunction

  // CPU result register: loads on save.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cpu_res <= 8'h00;
    else if (save) cpu_res <= alu(opcode, a, b);
  end
  assign result_in = cpu_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [19:0] word);
    prog_we = 1'b1;
    prog_addr = addr[3:0];
    prog_wdata = word;
    tick();
    prog_we = 1'b0;
    ref_mem[addr] = word;
  endtask

  function automatic logic [19:0] rand_word(input bit allow_halt);
    logic [19:0] w;
    w = 20'($urandom);
    w[19] = allow_halt && ($urandom_range(0, 3) == 0);
    return w;
  endfunction

`ifndef SEQ_LOOP_EN
  // Runs from address 0 and checks every save and the done pulse against the model.
  // wr0: write w0 to address 0 in the same cycle as start.
  // disturb: pulse prog_we and start mid-run; both must be ignored.
  task automatic run_prog(input string tag, input bit wr0, input logic [19:0] w0,
                          input bit disturb);
    int n, k, addr;
    bit seen;
    logic [19:0] w;
    if (wr0) begin
      prog_we = 1'b1;
      prog_addr = 4'd0;
      prog_wdata = w0;
    end
    start = 1'b1;
    tick();
    prog_we = 1'b0;
    start = 1'b0;
    if (wr0) ref_mem[0] = w0;
    exp_q.delete();
    addr = 0;
    forever begin
      exp_q.push_back(addr);
      if (ref_mem[addr][19] || addr == DEPTH - 1) break;
      addr++;
    end
    n = exp_q.size();
    k = 0;
    seen = 1'b0;
    for (int c = 1; c <= 4 * DEPTH + 8; c++) begin
      if (c == 1) check({tag, "/busy_rise"}, busy, 1);
      else if (!busy) check({tag, "/busy_drop"}, busy, 1);
      if (disturb && c == 2) begin
        prog_we = 1'b1;
        prog_addr = 4'd0;
        prog_wdata = ~ref_mem[0];
        start = 1'b1;
      end
      if (disturb && c == 3) begin
        prog_we = 1'b0;
        start = 1'b0;
      end
      if (save) begin
        if (k < n) begin
          w = ref_mem[exp_q[k]];
          check({tag, "/save_cycle"}, c, 4 * k + 3);
          check({tag, "/pc"}, pc, exp_q[k]);
          check({tag, "/op_a_b"}, {opcode, a, b}, w[18:0]);
        end else begin
          check({tag, "/extra_save"}, k, n);
        end
        k++;
      end
      if (done) begin
        w = ref_mem[exp_q[n-1]];
        check({tag, "/done_cycle"}, c, 4 * n + 1);
        check({tag, "/save_count"}, k, n);
        check({tag, "/result"}, result_out, alu(w[18:16], w[15:8], w[7:0]));
        check({tag, "/busy_in_done"}, busy, 1);
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) begin
      check({tag, "/timeout"}, 0, 1);
    end else begin
      tick();
      check({tag, "/busy_fall"}, {busy, done}, 2'b00);
      repeat (3) tick();
      check({tag, "/stays_idle"}, {busy, save}, 2'b00);
    end
  endtask
`endif

  task automatic check_reset_outputs(input string tag);
    check({tag, "/outs"}, {opcode, a, b, save, result_out, pc, busy, done}, 0);
  endtask

  initial begin
    // Reset state
    #12;
    check_reset_outputs("por");
    reset_n = 1'b1;
    tick();

`ifndef SEQ_LOOP_EN
    // Two-instruction directed program: add then halt on sub
    load(0, {1'b0, 3'b000, 8'h05, 8'h03});
    load(1, {1'b1, 3'b001, 8'h09, 8'h04});
    run_prog("two_instr", 1'b0, '0, 1'b0);
    check("two_instr/result_const", result_out, 8'h05);

    // Full store, no halt bits; stop must be ignored in this build
    for (int i = 0; i < DEPTH; i++) load(i, rand_word(1'b0));
    stop = 1'b1;
    run_prog("full_store", 1'b0, '0, 1'b0);
    stop = 1'b0;
    check("full_store/pc_end", pc, 4'hf);

    // Random programs with random halt positions
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < DEPTH; i++) load(i, rand_word(1'b1));
      run_prog("random", 1'b0, '0, 1'b0);
    end

    // Writes and start while busy are dropped; rerun proves the store is unchanged
    ref_mem[2][19] = 1'b1;
    load(2, ref_mem[2]);
    run_prog("busy_lockout", 1'b0, '0, 1'b1);
    run_prog("busy_lockout_rerun", 1'b0, '0, 1'b0);

    // Write and start in the same IDLE cycle: new word executes
    run_prog("write_start", 1'b1, {1'b1, 3'b100, 8'hA5, 8'h3C}, 1'b0);
    check("write_start/result_const", result_out, 8'h99);

    // Reset mid-program, then rerun to confirm the store survived
    for (int i = 0; i < DEPTH; i++) load(i, rand_word(1'b0));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    #2 reset_n = 1'b1;
    tick();
    check("post_reset/idle", {busy, done, save}, 3'b000);
    run_prog("post_reset_rerun", 1'b0, '0, 1'b0);
`else
    // Loop build: halt at address 2, stop during CAPTURE of the 5th instruction (addr 1)
    begin
      int k;
      bit seen;
      logic [19:0] w;
      load(0, rand_word(1'b0));
      load(1, rand_word(1'b0));
      w = rand_word(1'b0);
      w[19] = 1'b1;
      load(2, w);
      for (int pass = 0; pass < 2; pass++) begin
        if (pass == 1) begin
          // Abort mid-loop with reset; the second pass proves the store survived.
          start = 1'b1;
          tick();
          start = 1'b0;
          repeat (9) tick();
          #2 reset_n = 1'b0;
          #1 check_reset_outputs("loop_mid_reset");
          #2 reset_n = 1'b1;
          tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        seen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
          if (save) begin
            check("loop/pc_seq", pc, k % 3);
            check("loop/save_cycle", c, 4 * k + 3);
            w = ref_mem[k % 3];
            check("loop/op_a_b", {opcode, a, b}, w[18:0]);
            k++;
          end
          if (c == 20) stop = 1'b1;
          if (c == 21) stop = 1'b0;
          if (done) begin
            check("loop/done_cycle", c, 21);
            w = ref_mem[1];
            check("loop/result", result_out, alu(w[18:16], w[15:8], w[7:0]));
            seen = 1'b1;
            break;
          end
          tick();
        end
        if (!seen) check("loop/timeout", 0, 1);
        tick();
        check("loop/busy_fall", busy, 0);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
